// File: rtl/noc_bridge_pkg.sv
// Shared types, sideband bit positions and helpers for the multi-VC NoC bridge.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_bridge_pkg;

    localparam int NOC_DATA_W = `Noc_Data_Width;

    // Stored FIFO word layout is {flit, is_header, is_tail}.
    localparam int TAIL_BIT = 0;
    localparam int HDR_BIT  = 1;
    localparam int SB_W     = 2;

    typedef struct packed {
        logic [NOC_DATA_W-1:0] flit;
        logic                  is_header;
        logic                  is_tail;
    } flit_sb_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

    function automatic int vc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Show-ahead per-VC flit FIFO with a DEPTH-exact occupancy count.
module noc_vc_fifo
    import noc_bridge_pkg::*;
#(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_wr, do_rd;

    assign do_wr = wr_en_i && (cnt_q != CW'(DEPTH));
    assign do_rd = rd_en_i && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;

endmodule

// File: rtl/noc_bridge_vc.sv
// Multi-VC bridge: per-VC receive FIFOs with packet-atomic RR arbiter,
// and a registered VC-tagged send stage with packet lock.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_bridge_vc
    import noc_bridge_pkg::*;
#(
    parameter int DATA_W = `Noc_Data_Width,
    parameter int NUM_VC = 2,
    parameter int VC_W   = vc_width(NUM_VC),
    parameter int DEPTH  = 4
) (
    input  logic              noc_clk,
    input  logic              rst_n,
    input  logic              Noc_receive_valid,
    output logic              Noc_receive_ready,
    input  logic [DATA_W-1:0] Noc_receive_flit,
    input  logic [VC_W-1:0]   Noc_receive_vc,
    output logic [NUM_VC-1:0] Noc_receive_VCready,
    input  logic              Noc_receive_is_header,
    input  logic              Noc_receive_is_tail,
    output logic              Noc_sender_valid,
    input  logic              Noc_sender_ready,
    output logic [DATA_W-1:0] Noc_sender_flit,
    output logic [VC_W-1:0]   Noc_sender_vc,
    input  logic [NUM_VC-1:0] Noc_sender_VCready,
    output logic              Noc_sender_is_header,
    output logic              Noc_sender_is_tail,
    output logic              local_rx_valid,
    input  logic              local_rx_ready,
    output logic [DATA_W-1:0] local_rx_flit,
    output logic [VC_W-1:0]   local_rx_vc,
    output logic              local_rx_is_header,
    output logic              local_rx_is_tail,
    input  logic              local_tx_valid,
    output logic              local_tx_ready,
    input  logic [DATA_W-1:0] local_tx_flit,
    input  logic [VC_W-1:0]   local_tx_vc,
    input  logic              local_tx_is_header,
    input  logic              local_tx_is_tail,
    output logic              err_vc_switch
);

    localparam int FW = DATA_W + SB_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     cnt    [NUM_VC];
    logic [FW-1:0]     head_w [NUM_VC];
    logic [NUM_VC-1:0] wr_en, rd_en;

    arb_state_e        state_q, state_d;
    logic [VC_W-1:0]   lock_vc_q, lock_vc_d;
    logic [VC_W-1:0]   rr_q, rr_d;
    logic [VC_W-1:0]   grant;
    logic [FW-1:0]     head;
    logic              head_vld, found, rx_fire;
    int                idx;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign Noc_receive_VCready[v] = cnt[v] < CW'(DEPTH);
        assign wr_en[v] = Noc_receive_valid && Noc_receive_ready
                       && (Noc_receive_vc == VC_W'(v));
        assign rd_en[v] = rx_fire && (grant == VC_W'(v));

        noc_vc_fifo #(
            .W     (FW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i     (noc_clk),
            .rst_ni    (rst_n),
            .wr_en_i   (wr_en[v]),
            .wr_data_i ({Noc_receive_flit, Noc_receive_is_header,
                         Noc_receive_is_tail}),
            .rd_en_i   (rd_en[v]),
            .rd_data_o (head_w[v]),
            .count_o   (cnt[v])
        );
    end

    always_comb begin
        Noc_receive_ready = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (Noc_receive_vc == VC_W'(v)) Noc_receive_ready = Noc_receive_VCready[v];
        end
    end

    // Locked: only the owning VC is visible, even if it is empty.
    always_comb begin
        grant = lock_vc_q;
        found = 1'b0;
        idx   = 0;
        if (state_q == ARB_IDLE) begin
            grant = rr_q;
            for (int i = 0; i < NUM_VC; i++) begin
                idx = (int'(rr_q) + i) % NUM_VC;
                if (!found && (cnt[idx] != '0)) begin
                    grant = VC_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head     = '0;
        head_vld = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (grant == VC_W'(v)) begin
                head     = head_w[v];
                head_vld = cnt[v] != '0;
            end
        end
    end

    assign local_rx_valid     = head_vld;
    assign local_rx_flit      = head[FW-1:SB_W];
    assign local_rx_is_header = head[HDR_BIT];
    assign local_rx_is_tail   = head[TAIL_BIT];
    assign local_rx_vc        = grant;
    assign rx_fire            = head_vld && local_rx_ready;

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_d      = rr_q;
        if (rx_fire) begin
            if (local_rx_is_tail) begin
                state_d = ARB_IDLE;
                rr_d    = (grant == VC_W'(NUM_VC - 1)) ? '0 : grant + 1'b1;
            end else if (local_rx_is_header && (state_q == ARB_IDLE)) begin
                state_d   = ARB_LOCK;
                lock_vc_d = grant;
            end
        end
    end

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            lock_vc_q <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_q      <= rr_d;
        end
    end

    logic            out_vld_q, out_vld_d;
    logic [FW-1:0]   out_q, out_d;
    logic [VC_W-1:0] out_vc_q, out_vc_d;
    logic            tx_lock_q, tx_lock_d;
    logic [VC_W-1:0] tx_lock_vc_q, tx_lock_vc_d;
    logic            err_q, err_d;
    logic            tx_vc_rdy, vc_ok, sender_fire, tx_acc;

    always_comb begin
        tx_vc_rdy = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (local_tx_vc == VC_W'(v)) tx_vc_rdy = Noc_sender_VCready[v];
        end
    end

    assign vc_ok          = !tx_lock_q || (local_tx_vc == tx_lock_vc_q);
    assign sender_fire    = out_vld_q && Noc_sender_ready;
    assign local_tx_ready = (!out_vld_q || sender_fire) && tx_vc_rdy && vc_ok;
    assign tx_acc         = local_tx_valid && local_tx_ready;

    always_comb begin
        out_vld_d    = out_vld_q;
        out_d        = out_q;
        out_vc_d     = out_vc_q;
        tx_lock_d    = tx_lock_q;
        tx_lock_vc_d = tx_lock_vc_q;
        err_d        = err_q;
        if (tx_acc) begin
            out_vld_d = 1'b1;
            out_d     = {local_tx_flit, local_tx_is_header, local_tx_is_tail};
            out_vc_d  = local_tx_vc;
            if (local_tx_is_tail) begin
                tx_lock_d = 1'b0;
            end else if (local_tx_is_header) begin
                tx_lock_d    = 1'b1;
                tx_lock_vc_d = local_tx_vc;
            end
        end else if (sender_fire) begin
            out_vld_d = 1'b0;
        end
        if (local_tx_valid && !vc_ok) err_d = 1'b1;
    end

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q    <= 1'b0;
            out_q        <= '0;
            out_vc_q     <= '0;
            tx_lock_q    <= 1'b0;
            tx_lock_vc_q <= '0;
            err_q        <= 1'b0;
        end else begin
            out_vld_q    <= out_vld_d;
            out_q        <= out_d;
            out_vc_q     <= out_vc_d;
            tx_lock_q    <= tx_lock_d;
            tx_lock_vc_q <= tx_lock_vc_d;
            err_q        <= err_d;
        end
    end

    assign Noc_sender_valid     = out_vld_q;
    assign Noc_sender_flit      = out_q[FW-1:SB_W];
    assign Noc_sender_is_header = out_q[HDR_BIT];
    assign Noc_sender_is_tail   = out_q[TAIL_BIT];
    assign Noc_sender_vc        = out_vc_q;
    assign err_vc_switch        = err_q;

endmodule

// File: tb/tb_noc_bridge_vc.sv
// Testbench for noc_bridge_vc: vector tables, lock sequences, randomized rx model.
module tb_noc_bridge_vc;
    import noc_bridge_pkg::*;

    localparam int DW = 8;
    localparam int NV = 2;
    localparam int VW = 1;
    localparam int DP = 4;

    logic          noc_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r_valid, r_ready, r_hdr, r_tail;
    logic [DW-1:0] r_flit;
    logic [VW-1:0] r_vc;
    logic [NV-1:0] r_vcready;
    logic          s_valid, s_ready, s_hdr, s_tail;
    logic [DW-1:0] s_flit;
    logic [VW-1:0] s_vc;
    logic [NV-1:0] s_vcready;
    logic          lrx_valid, lrx_ready, lrx_hdr, lrx_tail;
    logic [DW-1:0] lrx_flit;
    logic [VW-1:0] lrx_vc;
    logic          ltx_valid, ltx_ready, ltx_hdr, ltx_tail;
    logic [DW-1:0] ltx_flit;
    logic [VW-1:0] ltx_vc;
    logic          err;

    always #5 noc_clk = ~noc_clk;

    noc_bridge_vc #(
        .DATA_W (DW),
        .NUM_VC (NV),
        .VC_W   (VW),
        .DEPTH  (DP)
    ) dut (
        .noc_clk               (noc_clk),
        .rst_n                 (rst_n),
        .Noc_receive_valid     (r_valid),
        .Noc_receive_ready     (r_ready),
        .Noc_receive_flit      (r_flit),
        .Noc_receive_vc        (r_vc),
        .Noc_receive_VCready   (r_vcready),
        .Noc_receive_is_header (r_hdr),
        .Noc_receive_is_tail   (r_tail),
        .Noc_sender_valid      (s_valid),
        .Noc_sender_ready      (s_ready),
        .Noc_sender_flit       (s_flit),
        .Noc_sender_vc         (s_vc),
        .Noc_sender_VCready    (s_vcready),
        .Noc_sender_is_header  (s_hdr),
        .Noc_sender_is_tail    (s_tail),
        .local_rx_valid        (lrx_valid),
        .local_rx_ready        (lrx_ready),
        .local_rx_flit         (lrx_flit),
        .local_rx_vc           (lrx_vc),
        .local_rx_is_header    (lrx_hdr),
        .local_rx_is_tail      (lrx_tail),
        .local_tx_valid        (ltx_valid),
        .local_tx_ready        (ltx_ready),
        .local_tx_flit         (ltx_flit),
        .local_tx_vc           (ltx_vc),
        .local_tx_is_header    (ltx_hdr),
        .local_tx_is_tail      (ltx_tail),
        .err_vc_switch         (err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic idle();
        r_valid = 0; r_flit = '0; r_vc = '0; r_hdr = 0; r_tail = 0;
        s_ready = 0; s_vcready = '1; lrx_ready = 0;
        ltx_valid = 0; ltx_flit = '0; ltx_vc = '0; ltx_hdr = 0; ltx_tail = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge noc_clk);
        #1;
        rst_n = 1;
    endtask

    typedef struct {
        logic          v;
        logic [DW-1:0] f;
        logic          lrr;
        logic          e_rdy;
        logic [NV-1:0] e_vcr;
        logic          e_lv;
        logic [DW-1:0] e_lf;
    } rxv_t;

    typedef struct {
        logic          tv;
        logic [VW-1:0] tvc;
        logic [DW-1:0] tf;
        logic          th, tt, sr;
        logic [NV-1:0] svr;
        logic          e_tr, e_sv;
        logic [DW-1:0] e_sf;
        logic [VW-1:0] e_svc;
        logic [1:0]    e_sht;
        logic          e_err;
    } txv_t;

    function automatic rxv_t mk_rx(logic v, logic [DW-1:0] f, logic lrr, logic e_rdy,
                                   logic [NV-1:0] e_vcr, logic e_lv, logic [DW-1:0] e_lf);
        rxv_t r;
        r.v = v; r.f = f; r.lrr = lrr; r.e_rdy = e_rdy;
        r.e_vcr = e_vcr; r.e_lv = e_lv; r.e_lf = e_lf;
        return r;
    endfunction

    function automatic txv_t mk_tx(logic tv, logic [VW-1:0] tvc, logic [DW-1:0] tf,
                                   logic th, logic tt, logic sr, logic [NV-1:0] svr,
                                   logic e_tr, logic e_sv, logic [DW-1:0] e_sf,
                                   logic [VW-1:0] e_svc, logic [1:0] e_sht, logic e_err);
        txv_t t;
        t.tv = tv; t.tvc = tvc; t.tf = tf; t.th = th; t.tt = tt; t.sr = sr;
        t.svr = svr; t.e_tr = e_tr; t.e_sv = e_sv; t.e_sf = e_sf;
        t.e_svc = e_svc; t.e_sht = e_sht; t.e_err = e_err;
        return t;
    endfunction

    rxv_t rxt[$];
    txv_t txt[$];
    logic [DW+VW-1:0] got[$];
    logic [DW+VW-1:0] want[$];
    logic [DW+1:0] mq [NV][$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // fill to depth, refuse 5th, pop restores space, then drain in order
        rxt.push_back(mk_rx(1, 8'h01, 0, 1, 2'b11, 0, 8'h00));
        rxt.push_back(mk_rx(1, 8'h02, 0, 1, 2'b11, 1, 8'h01));
        rxt.push_back(mk_rx(1, 8'h03, 0, 1, 2'b11, 1, 8'h01));
        rxt.push_back(mk_rx(1, 8'h04, 0, 1, 2'b11, 1, 8'h01));
        rxt.push_back(mk_rx(1, 8'h05, 0, 0, 2'b10, 1, 8'h01));
        rxt.push_back(mk_rx(1, 8'h05, 1, 0, 2'b10, 1, 8'h01));
        rxt.push_back(mk_rx(1, 8'h05, 0, 1, 2'b11, 1, 8'h02));
        rxt.push_back(mk_rx(0, 8'h00, 0, 0, 2'b10, 1, 8'h02));
        rxt.push_back(mk_rx(0, 8'h00, 1, 0, 2'b10, 1, 8'h02));
        rxt.push_back(mk_rx(0, 8'h00, 1, 1, 2'b11, 1, 8'h03));
        rxt.push_back(mk_rx(0, 8'h00, 1, 1, 2'b11, 1, 8'h04));
        rxt.push_back(mk_rx(0, 8'h00, 1, 1, 2'b11, 1, 8'h05));
        rxt.push_back(mk_rx(0, 8'h00, 0, 1, 2'b11, 0, 8'h00));

        // send A/B/C on VC1 with stall, VCready gating, then VC-switch error
        txt.push_back(mk_tx(1, 1, 8'hA1, 1, 0, 1, 2'b11, 1, 0, 8'h00, 0, 2'b00, 0));
        txt.push_back(mk_tx(1, 1, 8'hB2, 0, 0, 1, 2'b11, 1, 1, 8'hA1, 1, 2'b10, 0));
        txt.push_back(mk_tx(1, 1, 8'hC3, 0, 1, 0, 2'b11, 0, 1, 8'hB2, 1, 2'b00, 0));
        txt.push_back(mk_tx(1, 1, 8'hC3, 0, 1, 1, 2'b11, 1, 1, 8'hB2, 1, 2'b00, 0));
        txt.push_back(mk_tx(0, 0, 8'h00, 0, 0, 1, 2'b11, 1, 1, 8'hC3, 1, 2'b01, 0));
        txt.push_back(mk_tx(0, 0, 8'h00, 0, 0, 1, 2'b11, 1, 0, 8'h00, 0, 2'b00, 0));
        txt.push_back(mk_tx(1, 1, 8'hD4, 1, 1, 1, 2'b01, 0, 0, 8'h00, 0, 2'b00, 0));
        txt.push_back(mk_tx(1, 1, 8'hD4, 1, 1, 1, 2'b01, 0, 0, 8'h00, 0, 2'b00, 0));
        txt.push_back(mk_tx(1, 1, 8'hD4, 1, 1, 1, 2'b11, 1, 0, 8'h00, 0, 2'b00, 0));
        txt.push_back(mk_tx(0, 0, 8'h00, 0, 0, 1, 2'b11, 1, 1, 8'hD4, 1, 2'b11, 0));
        txt.push_back(mk_tx(1, 0, 8'hE5, 1, 0, 1, 2'b11, 1, 0, 8'h00, 0, 2'b00, 0));
        txt.push_back(mk_tx(1, 1, 8'hF6, 0, 0, 1, 2'b11, 0, 1, 8'hE5, 0, 2'b10, 0));
        txt.push_back(mk_tx(1, 1, 8'hF6, 0, 0, 1, 2'b11, 0, 0, 8'h00, 0, 2'b00, 1));
        txt.push_back(mk_tx(1, 0, 8'h17, 0, 1, 1, 2'b11, 1, 0, 8'h00, 0, 2'b00, 1));
        txt.push_back(mk_tx(0, 0, 8'h00, 0, 0, 1, 2'b11, 1, 1, 8'h17, 0, 2'b01, 1));
        txt.push_back(mk_tx(0, 0, 8'h00, 0, 0, 1, 2'b11, 1, 0, 8'h00, 0, 2'b00, 1));

        // reset state
        do_reset();
        #1;
        chk("rst.vcready", r_vcready, 2'b11);
        chk("rst.rready", r_ready, 1);
        chk("rst.lrx_valid", lrx_valid, 0);
        chk("rst.s_valid", s_valid, 0);
        chk("rst.s_data", {s_flit, s_hdr, s_tail}, '0);
        chk("rst.err", err, 0);

        // receive table
        foreach (rxt[i]) begin
            r_valid = rxt[i].v; r_flit = rxt[i].f; r_vc = 0;
            r_hdr = 0; r_tail = 0; lrx_ready = rxt[i].lrr;
            #1;
            chk($sformatf("rx[%0d].rready", i), r_ready, rxt[i].e_rdy);
            chk($sformatf("rx[%0d].vcready", i), r_vcready, rxt[i].e_vcr);
            chk($sformatf("rx[%0d].lrx_valid", i), lrx_valid, rxt[i].e_lv);
            if (rxt[i].e_lv)
                chk($sformatf("rx[%0d].lrx_flit", i), lrx_flit, rxt[i].e_lf);
            tick();
        end

        // interleaved packets: VC0 packet stays contiguous, VC1 hidden while locked
        do_reset();
        lrx_ready = 1;
        for (int c = 0; c < 10; c++) begin
            r_valid = (c < 4);
            unique case (c)
                0: begin r_vc = 0; r_flit = 8'h10; r_hdr = 1; r_tail = 0; end
                1: begin r_vc = 1; r_flit = 8'h20; r_hdr = 1; r_tail = 1; end
                2: begin r_vc = 0; r_flit = 8'h11; r_hdr = 0; r_tail = 0; end
                3: begin r_vc = 0; r_flit = 8'h12; r_hdr = 0; r_tail = 1; end
                default: begin r_vc = 0; r_flit = 0; r_hdr = 0; r_tail = 0; end
            endcase
            #1;
            if (c == 2) chk("lock.hide_vc1", lrx_valid, 0);
            if (lrx_valid) got.push_back({lrx_vc, lrx_flit});
            tick();
        end
        idle();
        want = '{{1'b0, 8'h10}, {1'b0, 8'h11}, {1'b0, 8'h12}, {1'b1, 8'h20}};
        chk("lock.count", got.size(), 4);
        foreach (want[i]) begin
            if (i < got.size()) chk($sformatf("lock.order[%0d]", i), got[i], want[i]);
        end
        chk("lock.rr_end", dut.rr_q, 0);

        // send table
        do_reset();
        foreach (txt[i]) begin
            ltx_valid = txt[i].tv; ltx_vc = txt[i].tvc; ltx_flit = txt[i].tf;
            ltx_hdr = txt[i].th; ltx_tail = txt[i].tt;
            s_ready = txt[i].sr; s_vcready = txt[i].svr;
            #1;
            chk($sformatf("tx[%0d].tx_ready", i), ltx_ready, txt[i].e_tr);
            chk($sformatf("tx[%0d].s_valid", i), s_valid, txt[i].e_sv);
            chk($sformatf("tx[%0d].err", i), err, txt[i].e_err);
            if (txt[i].e_sv)
                chk($sformatf("tx[%0d].s_data", i), {s_vc, s_flit, s_hdr, s_tail},
                    {txt[i].e_svc, txt[i].e_sf, txt[i].e_sht});
            tick();
        end

        // reset clears sticky error
        do_reset();
        #1;
        chk("err.after_reset", err, 0);

        // reset mid-packet drops the send lock
        ltx_valid = 1; ltx_vc = 0; ltx_flit = 8'h33; ltx_hdr = 1; ltx_tail = 0;
        s_ready = 0;
        tick();
        do_reset();
        ltx_valid = 1; ltx_vc = 1; ltx_flit = 8'h44; ltx_hdr = 1; ltx_tail = 1;
        #1;
        chk("midrst.s_valid", s_valid, 0);
        chk("midrst.tx_ready", ltx_ready, 1);
        tick();
        chk("midrst.err", err, 0);

        // randomized receive path against a queue model
        do_reset();
        begin
            int m_lock = -1;
            int m_rr = 0;
            int glen [NV];
            int gpos [NV];
            foreach (glen[v]) begin glen[v] = $urandom_range(1, 3); gpos[v] = 0; end
            for (int c = 0; c < 400; c++) begin
                int vc, g;
                logic ev, erdy;
                logic [DW+1:0] item;
                logic [VW-1:0] gv;
                vc = $urandom_range(0, NV - 1);
                r_valid = ($urandom_range(0, 99) < 70);
                r_vc = vc[VW-1:0];
                r_flit = DW'($urandom);
                r_hdr = (gpos[vc] == 0);
                r_tail = (gpos[vc] == glen[vc] - 1);
                lrx_ready = ($urandom_range(0, 99) < 60);
                #1;
                erdy = mq[vc].size() < DP;
                chk($sformatf("rnd[%0d].rready", c), r_ready, erdy);
                ev = 0;
                g = 0;
                if (m_lock >= 0) begin
                    g = m_lock;
                    ev = mq[g].size() > 0;
                end else begin
                    for (int i = 0; i < NV; i++) begin
                        int k;
                        k = (m_rr + i) % NV;
                        if (!ev && mq[k].size() > 0) begin g = k; ev = 1; end
                    end
                end
                gv = g[VW-1:0];
                chk($sformatf("rnd[%0d].lrx_valid", c), lrx_valid, ev);
                if (ev) begin
                    chk($sformatf("rnd[%0d].lrx_data", c),
                        {lrx_vc, lrx_flit, lrx_hdr, lrx_tail}, {gv, mq[g][0]});
                    if (lrx_ready) begin
                        item = mq[g].pop_front();
                        if (item[0]) begin
                            m_lock = -1;
                            m_rr = (g + 1) % NV;
                        end else if (item[1] && m_lock < 0) begin
                            m_lock = g;
                        end
                    end
                end
                if (r_valid && erdy) begin
                    mq[vc].push_back({r_flit, r_hdr, r_tail});
                    gpos[vc]++;
                    if (gpos[vc] == glen[vc]) begin
                        gpos[vc] = 0;
                        glen[vc] = $urandom_range(1, 3);
                    end
                end
                tick();
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
